scan_chain_driver: RTL and testbench

- Sequences the shared scan chain that feeds the small per-design wrappers: shifts an input vector into the selected design's slot, latches it, captures that design's outputs, and shifts them back out.
- One transaction per `start`. Sits between the top-level host logic and the chain of NUM_DESIGNS wrappers, each holding NUM_IOS scan flops.
- Lets the combinational, counter and morse designs be exercised one at a time through a single serial path.

---
 rtl/scan_chain_driver.sv | 155 +++++++++++++++
 tb/tb_scan_chain_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_driver.sv
// Sequences one scan-chain transaction: shift in, latch, capture, shift out, publish.
// Optional SCAN_DRV_REPEAT_EN adds repeat_en to chain transactions back to back.
module scan_chain_driver #(
  parameter int NUM_DESIGNS = 4,
  parameter int NUM_IOS     = 8,
  parameter int SEL_W       = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SEL_W-1:0]   design_sel,
  input  logic [NUM_IOS-1:0] inputs,
`ifdef SCAN_DRV_REPEAT_EN
  input  logic               repeat_en,
`endif
  output logic               busy,
  output logic               done,
  output logic [NUM_IOS-1:0] outputs,
  output logic               scan_clk,
  output logic               scan_data_out,
  input  logic               scan_data_in,
  output logic               scan_select,
  output logic               scan_latch_en
);
  localparam int L  = NUM_DESIGNS * NUM_IOS;
  localparam int CW = $clog2(2 * L);
  localparam int IW = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * L - 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT_IN, S_LATCH, S_CAPTURE, S_SHIFT_OUT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_IOS-1:0] in_q, in_d, shadow_q, shadow_d, outputs_q, outputs_d;
  logic busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, sdo_q, sdo_d;
  logic ssel_q, ssel_d, slat_q, slat_d;

  logic [31:0]   k, pos, base;
  logic [IW-1:0] idx;
  logic          in_slot, phase, rpt;

  always_comb begin
    k       = 32'(cnt_q) >> 1;
    pos     = 32'(L - 1) - k;
    base    = 32'(sel_q) * 32'(NUM_IOS);
    in_slot = (pos >= base) && (pos < base + 32'(NUM_IOS));
    idx     = IW'(pos - base);
    phase   = cnt_q[0];
`ifdef SCAN_DRV_REPEAT_EN
    rpt = repeat_en;
`else
    rpt = 1'b0;
`endif

    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    in_d     = in_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: if (start) begin
        sel_d    = design_sel;
        in_d     = inputs;
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = S_SHIFT_IN;
      end
      S_SHIFT_IN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        cnt_d = cnt_q + 1'b1;
        if (phase) begin
          cnt_d   = '0;
          state_d = S_SHIFT_OUT;
        end
      end
      S_SHIFT_OUT: begin
        // Pins lag state by a cycle, so the pin-level phase-0 window ends on a state phase-1 edge.
        if (phase && in_slot) shadow_d[idx] = scan_data_in;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (rpt) begin
          sel_d    = design_sel;
          in_d     = inputs;
          shadow_d = '0;
          cnt_d    = '0;
          state_d  = S_SHIFT_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered pin values decoded from the current state.
    busy_d    = (state_q == S_SHIFT_IN) || (state_q == S_LATCH) ||
                (state_q == S_CAPTURE)  || (state_q == S_SHIFT_OUT);
    sclk_d    = ((state_q == S_SHIFT_IN) || (state_q == S_CAPTURE) ||
                 (state_q == S_SHIFT_OUT)) && phase;
    sdo_d     = (state_q == S_SHIFT_IN) && in_slot && in_q[idx];
    ssel_d    = (state_q == S_CAPTURE);
    slat_d    = (state_q == S_LATCH);
    done_d    = (state_q == S_DONE);
    outputs_d = (state_q == S_DONE) ? shadow_q : outputs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      in_q      <= '0;
      shadow_q  <= '0;
      outputs_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      ssel_q    <= 1'b0;
      slat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      in_q      <= in_d;
      shadow_q  <= shadow_d;
      outputs_q <= outputs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      ssel_q    <= ssel_d;
      slat_q    <= slat_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign outputs       = outputs_q;
  assign scan_clk      = sclk_q;
  assign scan_data_out = sdo_q;
  assign scan_select   = ssel_q;
  assign scan_latch_en = slat_q;
endmodule

// File: tb/tb_scan_chain_driver.sv
// Drives scan_chain_driver against a behavioural wrapper chain (counter, decoder, incrementer, xor)
// and a transaction-level reference of what each design should report.
module tb_scan_chain_driver;
  localparam int ND = 4, NI = 8, L = ND * NI, SW = 2, LAT = 4 * L + 5;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [SW-1:0] design_sel = '0;
  logic [NI-1:0] inputs = '0;
  logic busy, done, scan_clk, scan_data_out, scan_data_in, scan_select, scan_latch_en;
  logic [NI-1:0] outputs;
`ifdef SCAN_DRV_REPEAT_EN
  logic repeat_en = 1'b0;
`endif

  always #5 clk = ~clk;

  scan_chain_driver #(.NUM_DESIGNS(ND), .NUM_IOS(NI)) dut (
    .clk(clk), .reset(reset), .start(start), .design_sel(design_sel), .inputs(inputs),
`ifdef SCAN_DRV_REPEAT_EN
    .repeat_en(repeat_en),
`endif
    .busy(busy), .done(done), .outputs(outputs), .scan_clk(scan_clk),
    .scan_data_out(scan_data_out), .scan_data_in(scan_data_in),
    .scan_select(scan_select), .scan_latch_en(scan_latch_en)
  );

  // Wrapper chain environment: position 0 is fed by the driver, position L-1 returns to it.
  logic [L-1:0]  chain = '0;
  logic [NI-1:0] din [ND];
  logic [NI-1:0] env_cnt = '0;
  initial for (int d = 0; d < ND; d++) din[d] = '0;
  assign scan_data_in = chain[L-1];

  function automatic logic [NI-1:0] dout(input int d);
    case (d)
      0: return env_cnt;
      1: return (din[1] == 8'h01) ? 8'hAA : (din[1] == 8'h02) ? 8'h55 : 8'h00;
      2: return din[2] + 8'h01;
      default: return din[3] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge scan_clk) begin
    if (scan_select) for (int d = 0; d < ND; d++) chain[d*NI +: NI] <= dout(d);
    else chain <= {chain[L-2:0], scan_data_out};
  end

  always @(posedge clk) begin
    if (scan_latch_en) begin
      for (int d = 0; d < ND; d++) din[d] <= chain[d*NI +: NI];
      if (!din[0][0] && chain[0]) env_cnt <= chain[1] ? 8'h00 : env_cnt + 8'h01;
    end
  end

  // Transaction-level reference
  int ref_cnt = 0;
  bit ref_prev0 = 1'b0;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NI-1:0] ref_txn(input logic [SW-1:0] s, input logic [NI-1:0] v);
    logic [NI-1:0] d0;
    d0 = (s == 0) ? v : 8'h00;
    if (!ref_prev0 && d0[0]) ref_cnt = d0[1] ? 0 : (ref_cnt + 1) % 256;
    ref_prev0 = d0[0];
    case (s)
      0: return 8'(ref_cnt);
      1: return (v == 8'h01) ? 8'hAA : (v == 8'h02) ? 8'h55 : 8'h00;
      2: return v + 8'h01;
      default: return v ^ 8'h5A;
    endcase
  endfunction

  task automatic run_txn(input logic [SW-1:0] s, input logic [NI-1:0] v, output int lat);
    @(posedge clk); #1;
    start = 1'b1; design_sel = s; inputs = v;
    lat = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end while (!done && lat < 400);
  endtask

  task automatic do_check(input string tag, input logic [SW-1:0] s, input logic [NI-1:0] v);
    int lat;
    logic [NI-1:0] exp;
    run_txn(s, v, lat);
    exp = ref_txn(s, v);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_out"}, outputs, exp);
    chk({tag, "_din"}, din[s], v);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int cnt;
    logic [NI-1:0] v;
    logic [SW-1:0] s;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", outputs, 0);
    chk("rst_sclk", scan_clk, 0);
    chk("rst_sdo", scan_data_out, 0);
    chk("rst_ssel", scan_select, 0);
    chk("rst_slat", scan_latch_en, 0);

    do_check("dec01", 1, 8'h01);
    chk("dec01_aa", outputs, 8'hAA);
    do_check("dec02", 1, 8'h02);
    chk("dec02_55", outputs, 8'h55);

    do_check("shin", 2, 8'hC3);
    chk("shin_d0", din[0], 0);
    chk("shin_d1", din[1], 0);
    chk("shin_d3", din[3], 0);

    do_check("cnt_r0", 0, 8'h02);
    do_check("cnt_r1", 0, 8'h03);
    chk("cnt_clr", outputs, 0);
    for (int i = 0; i < 5; i++) begin
      do_check("cnt_lo", 0, 8'h00);
      do_check("cnt_hi", 0, 8'h01);
    end
    chk("cnt_five", outputs, 8'h05);

    // Reset in the middle of a transaction
    @(posedge clk); #1;
    start = 1'b1; design_sel = 3; inputs = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sclk", scan_clk, 0);
    chk("abort_sdo", scan_data_out, 0);
    chk("abort_out", outputs, 0);
    cnt = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("abort_nodone", cnt, 0);
    do_check("post_abort", 1, 8'h01);

    // start held high through a whole transaction
    @(posedge clk); #1;
    start = 1'b1; design_sel = 1; inputs = 8'h02;
    cnt = 0;
    repeat (260) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    start = 1'b0;
    chk("held_one_done", cnt, 1);
    repeat (300) @(posedge clk);
    #1;
    chk("held_out", outputs, 8'h55);
    void'(ref_txn(1, 8'h02));
    void'(ref_txn(1, 8'h02));

    for (int i = 0; i < 10; i++) begin
      s = SW'($urandom_range(0, ND - 1));
      v = NI'($urandom);
      do_check("rnd", s, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
